ps2_scancode_decoder: RTL and testbench
=======================================

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: key_on  input  1  one-cycle strobe from ps2 receiver; key_value valid this cycle.
REQ-004 SHALL have ports: key_value  input  8  received set-2 scan code byte.
REQ-005 SHALL have ports: rd_en  input  1  consumer (LCD writer) pops head entry.
REQ-006 SHALL have ports: ascii_out  output  8  FIFO head character, first-word-fall-through; 8'h00 when empty.
REQ-007 SHALL have ports: empty  output  1  FIFO holds no characters.
REQ-008 SHALL have ports: overflow  output  1  sticky; a character was dropped on full FIFO.
REQ-009 SHALL have ports: caps_led  output  1  current Caps Lock state.
REQ-010 SHALL have parameter: FIFO_DEPTH, default 4, number of character entries (power of 2).

Function
REQ-011 SHALL act only on cycles with key_on=1; key_value ignored otherwise.
REQ-012 SHALL run prefix FSM, states IDLE, BRK, EXT, EXT_BRK; IDLE + F0 -> BRK; IDLE + E0 -> EXT; EXT + F0 -> EXT_BRK; any other byte in BRK/EXT/EXT_BRK -> IDLE after processing.
REQ-013 SHALL treat byte in IDLE (not E0/F0) as make, in BRK as break, in EXT/EXT_BRK as extended and discard it (no output, no modifier change).
REQ-014 SHALL set shift_l on make 12, clear on break 12; shift_r same for 59; shift = shift_l | shift_r.
REQ-015 SHALL toggle caps_led on make 58 only when caps_held=0, then set caps_held; break 58 clears caps_held (typematic repeats of 58 do not re-toggle).
REQ-016 SHALL map make codes: letters 1C a,32 b,21 c,23 d,24 e,2B f,34 g,33 h,43 i,3B j,42 k,4B l,3A m,31 n,44 o,4D p,15 q,2D r,1B s,2C t,3C u,2A v,1D w,22 x,35 y,1A z.
REQ-017 SHALL output letter uppercase (41-5A) when shift XOR caps_led, else lowercase (61-7A).
REQ-018 SHALL map digits 45 '0',16 '1',1E '2',26 '3',25 '4',2E '5',36 '6',3D '7',3E '8',46 '9' (30-39), unaffected by shift/caps.
REQ-019 SHALL map 29 -> 20 (space), 5A -> 0D (enter), 66 -> 08 (backspace).
REQ-020 SHALL push nothing for modifier codes, break codes, or unmapped make codes.
REQ-021 SHALL use modifier state as held before the current byte when mapping it.
REQ-022 SHALL write mapped character into FIFO on the same rising edge key_on is sampled; empty deasserts and ascii_out valid after that edge (latency 1 clk).
REQ-023 SHALL pop on rising edge when rd_en=1 and empty=0; rd_en while empty ignored, no underflow.
REQ-024 SHALL, on push while full with no pop, drop character, set overflow=1 until reset; contents unchanged.
REQ-025 SHALL, on simultaneous push and pop while full, perform both; count unchanged, overflow not set.
REQ-026 SHALL, on simultaneous push and pop while empty, perform push only.
REQ-027 SHALL wrap read/write pointers modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

Reset
REQ-028 SHALL, on rst_n=0 at any time, immediately set FSM IDLE, shift_l=shift_r=caps_held=0, caps_led=0, pointers/count 0, empty=1, overflow=0, ascii_out=00; partial prefix sequences discarded.
REQ-029 SHALL resume normal decode on first key_on after rst_n rises.

Verification
REQ-030 SHALL cover: 12,1C,F0,1C,F0,12 -> one entry 41 ('A'); shift cleared after.
REQ-031 SHALL cover: 58,F0,58,1C,F0,1C -> caps_led=1, entry 41; then 12,1C -> entry 61 ('a').
REQ-032 SHALL cover: 58,58,58,F0,58 -> caps_led toggles once to 1.
REQ-033 SHALL cover: E0,75,E0,F0,75,16 -> only entry 31 ('1'); FSM back in IDLE.
REQ-034 SHALL cover: five makes 1C,32,21,23,24 with no rd_en -> entries 61,62,63,64 read in order, overflow=1; push+pop when full -> no overflow change, count 4.
REQ-035 SHALL cover: F0 then rst_n pulse, then 1C -> entry 61 (break prefix discarded), overflow=0.

Source files
------------

// File: rtl/ps2_scancode_decoder_if.sv
// Keyboard-to-consumer bus: scan-code strobes in, decoded ASCII FIFO head and status out.
interface ps2_scancode_decoder_if;
    logic       key_on;
    logic [7:0] key_value;
    logic       rd_en;
    logic [7:0] ascii_out;
    logic       empty;
    logic       overflow;
    logic       caps_led;

    modport master (
        output key_on, key_value, rd_en,
        input  ascii_out, empty, overflow, caps_led
    );

    modport slave (
        input  key_on, key_value, rd_en,
        output ascii_out, empty, overflow, caps_led
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan code decoder: prefix FSM, shift/caps modifiers, ASCII mapping into a
// first-word-fall-through character FIFO with sticky overflow.
module ps2_scancode_decoder #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ps2_scancode_decoder_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t             state, state_next;
    logic               shift_l, shift_r, caps_held, caps_led;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_nx;
    logic [CNT_W-1:0]   count, count_nx;
    logic [7:0]         ascii_q;
    logic               empty_q, overflow_q;
    logic [7:0]         mem [FIFO_DEPTH];

    logic               make_c, break_c, push_c, pop_c, full_c, do_push_c, drop_c;
    logic [7:0]         lc_c, digit_c, char_c, head_nx;

    function automatic logic [7:0] letter_lc(input logic [7:0] code);
        case (code)
            8'h1C: letter_lc = 8'h61;  8'h32: letter_lc = 8'h62;
            8'h21: letter_lc = 8'h63;  8'h23: letter_lc = 8'h64;
            8'h24: letter_lc = 8'h65;  8'h2B: letter_lc = 8'h66;
            8'h34: letter_lc = 8'h67;  8'h33: letter_lc = 8'h68;
            8'h43: letter_lc = 8'h69;  8'h3B: letter_lc = 8'h6A;
            8'h42: letter_lc = 8'h6B;  8'h4B: letter_lc = 8'h6C;
            8'h3A: letter_lc = 8'h6D;  8'h31: letter_lc = 8'h6E;
            8'h44: letter_lc = 8'h6F;  8'h4D: letter_lc = 8'h70;
            8'h15: letter_lc = 8'h71;  8'h2D: letter_lc = 8'h72;
            8'h1B: letter_lc = 8'h73;  8'h2C: letter_lc = 8'h74;
            8'h3C: letter_lc = 8'h75;  8'h2A: letter_lc = 8'h76;
            8'h1D: letter_lc = 8'h77;  8'h22: letter_lc = 8'h78;
            8'h35: letter_lc = 8'h79;  8'h1A: letter_lc = 8'h7A;
            default: letter_lc = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] digit_ascii(input logic [7:0] code);
        case (code)
            8'h45: digit_ascii = 8'h30;  8'h16: digit_ascii = 8'h31;
            8'h1E: digit_ascii = 8'h32;  8'h26: digit_ascii = 8'h33;
            8'h25: digit_ascii = 8'h34;  8'h2E: digit_ascii = 8'h35;
            8'h36: digit_ascii = 8'h36;  8'h3D: digit_ascii = 8'h37;
            8'h3E: digit_ascii = 8'h38;  8'h46: digit_ascii = 8'h39;
            default: digit_ascii = 8'h00;
        endcase
    endfunction

    // Prefix decode: classify the current byte and pick the next prefix state
    always_comb begin
        state_next = state;
        make_c     = 1'b0;
        break_c    = 1'b0;
        if (bus.key_on) begin
            case (state)
                IDLE: begin
                    if (bus.key_value == 8'hF0)      state_next = BRK;
                    else if (bus.key_value == 8'hE0) state_next = EXT;
                    else                             make_c     = 1'b1;
                end
                BRK: begin
                    break_c    = 1'b1;
                    state_next = IDLE;
                end
                EXT:     state_next = (bus.key_value == 8'hF0) ? EXT_BRK : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Character mapping uses modifier state from before this byte
    always_comb begin
        lc_c    = letter_lc(bus.key_value);
        digit_c = digit_ascii(bus.key_value);
        char_c  = 8'h00;
        if (lc_c != 8'h00)
            char_c = ((shift_l | shift_r) ^ caps_led) ? (lc_c - 8'h20) : lc_c;
        else if (digit_c != 8'h00)
            char_c = digit_c;
        else begin
            case (bus.key_value)
                8'h29:   char_c = 8'h20;
                8'h5A:   char_c = 8'h0D;
                8'h66:   char_c = 8'h08;
                default: char_c = 8'h00;
            endcase
        end
        push_c = make_c && (char_c != 8'h00);
    end

    // FIFO control and next head; a push landing on the new head slot bypasses memory
    always_comb begin
        pop_c     = bus.rd_en && !empty_q;
        full_c    = (count == CNT_W'(FIFO_DEPTH));
        do_push_c = push_c && (!full_c || pop_c);
        drop_c    = push_c && full_c && !pop_c;
        rd_ptr_nx = pop_c ? (rd_ptr + PTR_W'(1)) : rd_ptr;
        case ({do_push_c, pop_c})
            2'b10:   count_nx = count + CNT_W'(1);
            2'b01:   count_nx = count - CNT_W'(1);
            default: count_nx = count;
        endcase
        if (count_nx == '0)
            head_nx = 8'h00;
        else if (do_push_c && (wr_ptr == rd_ptr_nx))
            head_nx = char_c;
        else
            head_nx = mem[rd_ptr_nx];
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= char_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_l    <= 1'b0;
            shift_r    <= 1'b0;
            caps_held  <= 1'b0;
            caps_led   <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            ascii_q    <= 8'h00;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state <= state_next;
            if (make_c) begin
                case (bus.key_value)
                    8'h12: shift_l <= 1'b1;
                    8'h59: shift_r <= 1'b1;
                    8'h58: begin
                        if (!caps_held) caps_led <= ~caps_led;
                        caps_held <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (break_c) begin
                case (bus.key_value)
                    8'h12:   shift_l   <= 1'b0;
                    8'h59:   shift_r   <= 1'b0;
                    8'h58:   caps_held <= 1'b0;
                    default: ;
                endcase
            end
            if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr  <= rd_ptr_nx;
            count   <= count_nx;
            ascii_q <= head_nx;
            empty_q <= (count_nx == '0);
            if (drop_c) overflow_q <= 1'b1;
        end
    end

    assign bus.ascii_out = ascii_q;
    assign bus.empty     = empty_q;
    assign bus.overflow  = overflow_q;
    assign bus.caps_led  = caps_led;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: queue-based behavioural model, per-cycle compare,
// directed key sequences and randomized scan-code traffic.
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    ps2_scancode_decoder_if bus();
    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    bit m_shl, m_shr, m_caps, m_held, m_brk, m_ext, m_ovf;
    bit run_cmp = 0;

    logic [7:0] letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                      8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                      8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    logic [7:0] pool [16] = '{8'hF0,8'hE0,8'h12,8'h59,8'h58,8'h1C,8'h1A,8'h45,8'h46,
                              8'h29,8'h5A,8'h66,8'h75,8'h16,8'h4D,8'h00};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_char(input logic [7:0] code);
        bit upper = (m_shl | m_shr) ^ m_caps;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == code) return upper ? 8'(8'h41 + i) : 8'(8'h61 + i);
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == code) return 8'(8'h30 + i);
        if (code == 8'h29) return 8'h20;
        if (code == 8'h5A) return 8'h0D;
        if (code == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    task automatic model_reset();
        mq.delete();
        {m_shl, m_shr, m_caps, m_held, m_brk, m_ext, m_ovf} = '0;
    endtask

    task automatic model_step(input bit kon, input logic [7:0] kv, input bit rd);
        logic [7:0] ch = 8'h00;
        bit pop = rd && (mq.size() > 0);
        if (kon) begin
            if (m_ext) begin
                if (!m_brk && kv == 8'hF0) m_brk = 1;
                else {m_brk, m_ext} = 2'b00;
            end else if (m_brk) begin
                if (kv == 8'h12) m_shl = 0;
                if (kv == 8'h59) m_shr = 0;
                if (kv == 8'h58) m_held = 0;
                m_brk = 0;
            end else if (kv == 8'hF0) m_brk = 1;
            else if (kv == 8'hE0) m_ext = 1;
            else begin
                ch = model_char(kv);
                if (kv == 8'h12) m_shl = 1;
                if (kv == 8'h59) m_shr = 1;
                if (kv == 8'h58) begin
                    if (!m_held) m_caps = !m_caps;
                    m_held = 1;
                end
            end
        end
        if (pop) void'(mq.pop_front());
        if (ch != 8'h00) begin
            if (mq.size() < DEPTH) mq.push_back(ch);
            else m_ovf = 1;
        end
    endtask

    task automatic cyc(input bit kon, input logic [7:0] kv, input bit rd);
        bus.key_on = kon; bus.key_value = kv; bus.rd_en = rd;
        @(posedge clk);
        model_step(kon, kv, rd);
        #1;
        bus.key_on = 0; bus.rd_en = 0;
    endtask

    task automatic keys(input logic [7:0] seq [$]);
        foreach (seq[i]) cyc(1'b1, seq[i], 1'b0);
    endtask

    task automatic pop1(); cyc(1'b0, 8'h00, 1'b1); endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (run_cmp) begin
                chk("ascii_out", bus.ascii_out, (mq.size() > 0) ? mq[0] : 8'h00);
                chk("empty", 8'(bus.empty), 8'(mq.size() == 0));
                chk("overflow", 8'(bus.overflow), 8'(m_ovf));
                chk("caps_led", 8'(bus.caps_led), 8'(m_caps));
            end
        end
    end

    initial begin
        bus.key_on = 0; bus.key_value = 8'h00; bus.rd_en = 0;
        rst_n = 0;
        model_reset();
        run_cmp = 1;
        @(posedge clk); #1;
        chk("rst_empty", 8'(bus.empty), 8'h01);
        chk("rst_ascii", bus.ascii_out, 8'h00);
        rst_n = 1;
        @(posedge clk); #1;

        // Shifted letter, then shift released
        keys('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12});
        chk("shift_A", bus.ascii_out, 8'h41);
        chk("shift_A_model", mq[0], 8'h41);
        pop1();
        chk("shift_A_popped", 8'(bus.empty), 8'h01);
        keys('{8'h1C});
        chk("shift_cleared", bus.ascii_out, 8'h61);
        pop1();

        // Caps lock, then shift cancels caps
        keys('{8'h58, 8'hF0, 8'h58, 8'h1C, 8'hF0, 8'h1C});
        chk("caps_on", 8'(bus.caps_led), 8'h01);
        chk("caps_A", bus.ascii_out, 8'h41);
        pop1();
        keys('{8'h12, 8'h1C});
        chk("caps_shift_a", bus.ascii_out, 8'h61);
        pop1();

        // Typematic caps repeat toggles once
        do_reset();
        keys('{8'h58, 8'h58, 8'h58, 8'hF0, 8'h58});
        chk("caps_once", 8'(bus.caps_led), 8'h01);

        // Extended codes discarded
        do_reset();
        keys('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h16});
        chk("ext_head", bus.ascii_out, 8'h31);
        pop1();
        chk("ext_single", 8'(bus.empty), 8'h01);

        // Overflow on fifth push, contents preserved
        do_reset();
        keys('{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24});
        chk("ovf_set", 8'(bus.overflow), 8'h01);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_order", bus.ascii_out, 8'(8'h61 + i));
            pop1();
        end
        chk("ovf_drained", 8'(bus.empty), 8'h01);

        // Push and pop together while full
        do_reset();
        keys('{8'h1C, 8'h32, 8'h21, 8'h23});
        cyc(1'b1, 8'h2B, 1'b1);
        chk("full_pp_ovf", 8'(bus.overflow), 8'h00);
        chk("full_pp_head", bus.ascii_out, 8'h62);
        for (int i = 0; i < 3; i++) pop1();
        chk("full_pp_tail", bus.ascii_out, 8'h66);
        pop1();
        chk("full_pp_count", 8'(bus.empty), 8'h01);

        // Push and pop together while empty
        cyc(1'b1, 8'h45, 1'b1);
        chk("empty_pp", bus.ascii_out, 8'h30);
        pop1();

        // Reset discards a pending break prefix
        do_reset();
        keys('{8'hF0});
        do_reset();
        keys('{8'h1C});
        chk("rst_prefix", bus.ascii_out, 8'h61);
        chk("rst_prefix_ovf", 8'(bus.overflow), 8'h00);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] kv;
            bit kon = ($urandom_range(0, 99) < 60);
            bit rd  = ($urandom_range(0, 99) < 35);
            if ($urandom_range(0, 3) == 0) kv = 8'($urandom_range(0, 255));
            else kv = pool[$urandom_range(0, 15)];
            if ($urandom_range(0, 499) == 0) do_reset();
            else cyc(kon, kv, rd);
        end

        run_cmp = 0;
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
